row_fifo_reader: RTL and testbench

- Consumer end of the SpMV row FIFO. Pops partial-product entries, accumulates them per matrix row, and emits one row sum per row on a valid/ready output.
- Each FIFO entry: MSB = row_last flag; low DATA_WIDTH-1 bits = signed product.
- Sits between the row FIFO read port and the y-vector writeback stage.
- The writer encodes an empty row as a single entry with last=1 and value 0.

---
 rtl/spmv_pkg.sv | 17 +
 rtl/row_fifo_reader_if.sv | 24 ++
 rtl/row_acc_add.sv | 18 +
 rtl/row_fifo_reader.sv | 136 +++++++++++++
 tb/tb_row_fifo_reader.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spmv_pkg.sv
// Shared SpMV types and row-FIFO entry layout, common to the row FIFO writer
// and the row_fifo_reader consumer.
package spmv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        EMIT = 2'd2,
        FIN  = 2'd3
    } row_rd_state_t;

    // Entry layout for the default 32-bit FIFO: {row_last, signed product}
    localparam int SPMV_DATA_WIDTH = 32;
    localparam int ROW_LAST_BIT    = SPMV_DATA_WIDTH - 1;
    localparam int VAL_MSB         = SPMV_DATA_WIDTH - 2;

endpackage

// File: rtl/row_fifo_reader_if.sv
// Row FIFO read port plus row-sum result stream; master is the reader side.
interface row_fifo_reader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = 40,
    parameter int ROW_WIDTH  = 16
);
    logic                  fifo_empty;
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [ROW_WIDTH-1:0]  out_row;
    logic [ACC_WIDTH-1:0]  out_sum;

    modport master (
        input  fifo_empty, fifo_data, out_ready,
        output fifo_rd_en, out_valid, out_row, out_sum
    );

    modport slave (
        output fifo_empty, fifo_data, out_ready,
        input  fifo_rd_en, out_valid, out_row, out_sum
    );
endinterface

// File: rtl/row_acc_add.sv
// Sign-extending accumulate adder with two's-complement overflow detect.
module row_acc_add #(
    parameter int VAL_WIDTH = 31,
    parameter int ACC_WIDTH = 40
) (
    input  logic [ACC_WIDTH-1:0] acc,
    input  logic [VAL_WIDTH-1:0] val,
    output logic [ACC_WIDTH-1:0] sum,
    output logic                 ovf
);
    logic [ACC_WIDTH-1:0] val_ext;

    assign val_ext = ACC_WIDTH'($signed(val));
    assign sum     = acc + val_ext;
    // Same-sign operands producing an opposite-sign result means the add wrapped
    assign ovf     = (acc[ACC_WIDTH-1] == val_ext[ACC_WIDTH-1]) &&
                     (sum[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);
endmodule

// File: rtl/row_fifo_reader.sv
// Row FIFO consumer: accumulates signed partial products per matrix row and
// hands one sum per row to the y-vector writeback stage.
module row_fifo_reader
    import spmv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = 40,
    parameter int ROW_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ROW_WIDTH-1:0] num_rows,
    row_fifo_reader_if.master    bus,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow
);
    localparam int                   VAL_WIDTH = DATA_WIDTH - 1;
    localparam logic [ROW_WIDTH-1:0] ROW_ONE   = ROW_WIDTH'(1);

    row_rd_state_t        state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [ACC_WIDTH-1:0] sum_q, sum_d;
    logic [ROW_WIDTH-1:0] row_q, row_d;
    logic [ROW_WIDTH-1:0] nrows_q, nrows_d;
    logic                 valid_q, valid_d;
    logic                 ovf_q, ovf_d;

    logic                 pop;
    logic                 entry_last;
    logic                 handshake;
    logic                 last_row;
    logic [ACC_WIDTH-1:0] add_sum;
    logic                 add_ovf;

    assign entry_last = bus.fifo_data[DATA_WIDTH-1];
    assign handshake  = valid_q && bus.out_ready;
    assign last_row   = (row_q == (nrows_q - ROW_ONE));

    row_acc_add #(
        .VAL_WIDTH (VAL_WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_add (
        .acc (acc_q),
        .val (bus.fifo_data[DATA_WIDTH-2:0]),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (num_rows != '0) ? ACC : FIN;
            ACC:     if (pop && entry_last) state_d = EMIT;
            EMIT:    if (handshake) state_d = last_row ? FIN : ACC;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Read enable is combinational so the FIFO pops on the same edge that
    // folds its head entry into the accumulator.
    always_comb begin
        pop            = (state_q == ACC) && !bus.fifo_empty;
        bus.fifo_rd_en = pop;
        busy           = (state_q != IDLE);
        done           = (state_q == FIN);
    end

    always_comb begin
        acc_d   = acc_q;
        sum_d   = sum_q;
        row_d   = row_q;
        nrows_d = nrows_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    nrows_d = num_rows;
                    row_d   = '0;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            ACC: begin
                if (pop) begin
                    acc_d = add_sum;
                    if (add_ovf) ovf_d = 1'b1;
                    if (entry_last) begin
                        sum_d   = add_sum;
                        acc_d   = '0;
                        valid_d = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (handshake) begin
                    valid_d = 1'b0;
                    if (!last_row) row_d = row_q + ROW_ONE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q   <= '0;
            sum_q   <= '0;
            row_q   <= '0;
            nrows_q <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            row_q   <= row_d;
            nrows_q <= nrows_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_sum   = sum_q;
    assign bus.out_row   = row_q;
    assign overflow      = ovf_q;

endmodule

// File: tb/tb_row_fifo_reader.sv
// Directed bench for row_fifo_reader with a per-frame row-sum model and a
// per-cycle protocol/result monitor.
module tb_row_fifo_reader;
    localparam int DW = 33;
    localparam int AW = 32;
    localparam int RW = 16;
    localparam longint LIM = longint'(1) << (AW - 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [RW-1:0] num_rows = '0;
    logic          busy, done, overflow;
    logic          stall = 1'b0;

    row_fifo_reader_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .ROW_WIDTH(RW)) bus ();

    row_fifo_reader #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .ROW_WIDTH(RW)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .num_rows (num_rows),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // Bench-side row FIFO; stall forces empty to model a writer gap
    logic [DW-1:0] mem [0:255];
    int wr_ptr = 0;
    int rd_ptr;
    int mptr = 0;

    assign bus.fifo_empty = (rd_ptr == wr_ptr) || stall;
    assign bus.fifo_data  = mem[rd_ptr[7:0]];

    always @(posedge clk or negedge reset) begin
        if (!reset)              rd_ptr <= 0;
        else if (bus.fifo_rd_en) rd_ptr <= rd_ptr + 1;
    end

    // Expected row results, in hand-off order
    logic [AW-1:0] q_sum [$];
    int            q_row [$];
    bit            q_ovf [$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] ent(input bit last, input longint v);
        logic [DW-1:0] e;
        e         = '0;
        e[DW-2:0] = v[DW-2:0];
        e[DW-1]   = last;
        return e;
    endfunction

    task automatic push(input bit last, input longint v);
        mem[wr_ptr[7:0]] = ent(last, v);
        wr_ptr++;
    endtask

    // Exact row sums in 64-bit; a row overflows once any prefix leaves the
    // signed AW range, and the flag stays set for the rest of the frame.
    task automatic expect_frame(input int n);
        bit            ovf;
        longint        s;
        logic [DW-1:0] e;
        int            guard;
        ovf = 1'b0;
        for (int r = 0; r < n; r++) begin
            s = 0;
            guard = 0;
            do begin
                e = mem[mptr[7:0]];
                mptr++;
                guard++;
                s = s + longint'($signed(e[DW-2:0]));
                if (s >= LIM || s < -LIM) ovf = 1'b1;
            end while (!e[DW-1] && guard < 64);
            q_sum.push_back(s[AW-1:0]);
            q_row.push_back(r);
            q_ovf.push_back(ovf);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int n);
        start    = 1'b1;
        num_rows = RW'(n);
        expect_frame(n);
        cyc();
        start    = 1'b0;
    endtask

    task automatic wait_row(input int r);
        int k;
        k = 0;
        @(negedge clk);
        while (!(bus.out_valid && bus.out_row == RW'(r)) && k < 50) begin
            k++;
            @(negedge clk);
        end
        chk("row_wait_budget", 64'(k < 50), 64'd1);
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        @(negedge clk);
        while (!done && k < 50) begin
            k++;
            @(negedge clk);
        end
        chk("done_wait_budget", 64'(k < 50), 64'd1);
    endtask

    task automatic monitor();
        bit            hold;
        logic [AW-1:0] hsum;
        logic [RW-1:0] hrow;
        hold = 1'b0;
        hsum = '0;
        hrow = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                hold = 1'b0;
            end else begin
                if (bus.fifo_rd_en) begin
                    chk("rd_en_while_empty", 64'(bus.fifo_empty), 64'd0);
                    chk("rd_en_while_valid", 64'(bus.out_valid), 64'd0);
                end
                if (hold) begin
                    chk("held_valid", 64'(bus.out_valid), 64'd1);
                    chk("held_sum", 64'(bus.out_sum), 64'(hsum));
                    chk("held_row", 64'(bus.out_row), 64'(hrow));
                end
                if (bus.out_valid && bus.out_ready) begin
                    chk("result_expected", 64'(q_sum.size() != 0), 64'd1);
                    if (q_sum.size() != 0) begin
                        chk("result_sum", 64'(bus.out_sum), 64'(q_sum[0]));
                        chk("result_row", 64'(bus.out_row), 64'(q_row[0]));
                        chk("result_ovf", 64'(overflow), 64'(q_ovf[0]));
                        void'(q_sum.pop_front());
                        void'(q_row.pop_front());
                        void'(q_ovf.pop_front());
                    end
                end
                if (done) chk("done_rows_left", 64'(q_sum.size()), 64'd0);
                hold = bus.out_valid && !bus.out_ready;
                hsum = bus.out_sum;
                hrow = bus.out_row;
            end
        end
    endtask

    initial begin
        int rp0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        bus.out_ready = 1'b1;
        #1 reset = 1'b0;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_sum", 64'(bus.out_sum), 64'd0);
        chk("rst_row", 64'(bus.out_row), 64'd0);
        chk("rst_rd_en", 64'(bus.fifo_rd_en), 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        fork monitor(); join_none

        // Single row: three back-to-back pops, result the cycle after the last
        push(0, 5); push(0, -3); push(1, 10);
        do_start(1);
        chk("t1_model_sum", 64'(q_sum[0]), 64'd12);
        @(negedge clk); chk("t1_pop1", 64'(bus.fifo_rd_en), 64'd1);
        chk("t1_busy", 64'(busy), 64'd1);
        cyc(); @(negedge clk); chk("t1_pop2", 64'(bus.fifo_rd_en), 64'd1);
        cyc(); @(negedge clk); chk("t1_pop3", 64'(bus.fifo_rd_en), 64'd1);
        cyc(); @(negedge clk);
        chk("t1_valid", 64'(bus.out_valid), 64'd1);
        chk("t1_sum", 64'(bus.out_sum), 64'd12);
        chk("t1_row", 64'(bus.out_row), 64'd0);
        chk("t1_no_pop", 64'(bus.fifo_rd_en), 64'd0);
        cyc(); @(negedge clk); chk("t1_done", 64'(done), 64'd1);
        cyc(); @(negedge clk); chk("t1_done_off", 64'(done), 64'd0);
        chk("t1_idle", 64'(busy), 64'd0);

        // Backpressure across two rows
        cyc();
        bus.out_ready = 1'b0;
        push(1, 7); push(0, 1); push(1, 2);
        do_start(2);
        chk("t2_model_r0", 64'(q_sum[0]), 64'd7);
        chk("t2_model_r1", 64'(q_sum[1]), 64'd3);
        wait_row(0);
        for (int i = 0; i < 4; i++) begin
            chk("t2_hold_sum", 64'(bus.out_sum), 64'd7);
            chk("t2_hold_row", 64'(bus.out_row), 64'd0);
            chk("t2_hold_no_pop", 64'(bus.fifo_rd_en), 64'd0);
            cyc(); @(negedge clk);
        end
        cyc();
        bus.out_ready = 1'b1;
        wait_row(1);
        chk("t2_sum_r1", 64'(bus.out_sum), 64'd3);
        wait_done();

        // Writer gap mid-row
        cyc();
        push(0, 4); push(1, 4);
        do_start(1);
        cyc();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_stall_no_pop", 64'(bus.fifo_rd_en), 64'd0);
            chk("t3_stall_no_valid", 64'(bus.out_valid), 64'd0);
            cyc();
        end
        stall = 1'b0;
        wait_row(0);
        chk("t3_sum", 64'(bus.out_sum), 64'd8);
        wait_done();

        // Zero-row frame with a stray entry left in the FIFO
        cyc();
        push(1, 9);
        rp0 = rd_ptr;
        do_start(0);
        @(negedge clk); chk("t4_done", 64'(done), 64'd1);
        chk("t4_no_pop", 64'(bus.fifo_rd_en), 64'd0);
        cyc(); @(negedge clk);
        chk("t4_done_off", 64'(done), 64'd0);
        chk("t4_idle", 64'(busy), 64'd0);
        chk("t4_pops", 64'(rd_ptr - rp0), 64'd0);

        // Start pulsed while accumulating row 1 is ignored
        cyc();
        push(0, 1); push(0, 2); push(1, 3);
        do_start(2);
        chk("t5_model_r0", 64'(q_sum[0]), 64'd9);
        chk("t5_model_r1", 64'(q_sum[1]), 64'd6);
        wait_row(0);
        chk("t5_sum_r0", 64'(bus.out_sum), 64'd9);
        cyc();
        stall    = 1'b1;
        start    = 1'b1;
        num_rows = RW'(5);
        cyc();
        start    = 1'b0;
        @(negedge clk);
        chk("t5_busy", 64'(busy), 64'd1);
        chk("t5_row_kept", 64'(bus.out_row), 64'd1);
        cyc();
        stall = 1'b0;
        wait_row(1);
        chk("t5_sum_r1", 64'(bus.out_sum), 64'd6);
        wait_done();

        // Empty-row encoding and a negative sum
        cyc();
        push(1, 0); push(0, -1); push(1, 1); push(1, -8);
        do_start(3);
        chk("t6_model_r2", 64'(q_sum[2]), 64'hFFFF_FFF8);
        wait_row(0); chk("t6_sum_r0", 64'(bus.out_sum), 64'd0);
        wait_row(1); chk("t6_sum_r1", 64'(bus.out_sum), 64'd0);
        wait_row(2); chk("t6_sum_r2", 64'(bus.out_sum), 64'hFFFF_FFF8);
        wait_done();

        // Signed overflow, sticky past the end of the frame
        cyc();
        push(0, 64'h7FFF_FFFF); push(1, 1);
        do_start(1);
        chk("t7_model_ovf", 64'(q_ovf[0]), 64'd1);
        wait_row(0);
        chk("t7_sum", 64'(bus.out_sum), 64'h8000_0000);
        chk("t7_ovf", 64'(overflow), 64'd1);
        wait_done();
        cyc(); @(negedge clk);
        chk("t7_ovf_sticky", 64'(overflow), 64'd1);

        // Asynchronous reset after two pops of a row
        cyc();
        push(0, 3); push(0, 4); push(1, 5);
        rp0 = rd_ptr;
        do_start(1);
        @(negedge clk); chk("t8_ovf_cleared", 64'(overflow), 64'd0);
        cyc(); cyc();
        chk("t8_two_pops", 64'(rd_ptr - rp0), 64'd2);
        #1 reset = 1'b0;
        #1;
        chk("t8_busy", 64'(busy), 64'd0);
        chk("t8_valid", 64'(bus.out_valid), 64'd0);
        chk("t8_sum", 64'(bus.out_sum), 64'd0);
        chk("t8_row", 64'(bus.out_row), 64'd0);
        chk("t8_rd_en", 64'(bus.fifo_rd_en), 64'd0);
        chk("t8_done", 64'(done), 64'd0);
        wr_ptr = 0;
        mptr   = 0;
        q_sum.delete();
        q_row.delete();
        q_ovf.delete();
        @(posedge clk);
        #1 reset = 1'b1;
        cyc();
        push(0, 6); push(1, 1);
        do_start(1);
        chk("t8_model_fresh", 64'(q_sum[0]), 64'd7);
        wait_row(0);
        chk("t8_fresh_sum", 64'(bus.out_sum), 64'd7);
        wait_done();

        cyc();
        chk("results_drained", 64'(q_sum.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
